// File: rtl/exec_datapath_if.sv
// Execute-stage bus between the CPU core (master) and exec_datapath (slave).
// Carries the issued instruction, its operands, the decoded read addresses and the write-back results.
interface exec_datapath_if;
  logic       instr_valid;
  logic [7:0] instruction;
  logic [7:0] pc;
  logic [1:0] reg_addr_0;
  logic [1:0] reg_addr_1;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       wb_valid;
  logic       wb_en;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       jump;
  logic       overflow;

  modport master (
    output instr_valid, instruction, pc, op_a, op_b,
    input  reg_addr_0, reg_addr_1,
    input  wb_valid, wb_en, wb_addr, wb_data, jump, overflow
  );

  modport slave (
    input  instr_valid, instruction, pc, op_a, op_b,
    output reg_addr_0, reg_addr_1,
    output wb_valid, wb_en, wb_addr, wb_data, jump, overflow
  );
endinterface

// File: rtl/exec_datapath.sv
// Execute/memory stage of the 8-bit 4-register CPU: decoder, ALU and 256x8 data memory.
// Optional macro DMEM_RESET_CLEAR_EN: reset also clears the data memory.
module exec_datapath (
  input  logic           clk,
  input  logic           rst_n,
  exec_datapath_if.slave bus
);
  localparam int unsigned DW         = 8;
  localparam int unsigned RW         = 2;
  localparam int unsigned OPW        = 4;
  localparam int unsigned DMEM_DEPTH = 256;

  localparam logic [OPW-1:0] OP_ADD  = 4'h0;
  localparam logic [OPW-1:0] OP_SUB  = 4'h1;
  localparam logic [OPW-1:0] OP_AND  = 4'h2;
  localparam logic [OPW-1:0] OP_OR   = 4'h3;
  localparam logic [OPW-1:0] OP_XOR  = 4'h4;
  localparam logic [OPW-1:0] OP_SLT  = 4'h5;
  localparam logic [OPW-1:0] OP_SLL  = 4'h6;
  localparam logic [OPW-1:0] OP_SRL  = 4'h7;
  localparam logic [OPW-1:0] OP_MOV  = 4'h8;
  localparam logic [OPW-1:0] OP_ADDI = 4'h9;
  localparam logic [OPW-1:0] OP_LW   = 4'hA;
  localparam logic [OPW-1:0] OP_SW   = 4'hB;
  localparam logic [OPW-1:0] OP_BEQ  = 4'hC;
  localparam logic [OPW-1:0] OP_BNE  = 4'hD;
  localparam logic [OPW-1:0] OP_J    = 4'hE;
  localparam logic [OPW-1:0] OP_JAL  = 4'hF;

  logic [OPW-1:0] w_opcode;
  logic [RW-1:0]  w_fa;
  logic [RW-1:0]  w_fb;
  logic [RW-1:0]  w_ra0;
  logic [RW-1:0]  w_ra1;
  logic [RW-1:0]  w_dest;
  logic           w_we;
  logic [DW-1:0]  w_add;
  logic [DW-1:0]  w_sub;
  logic [DW-1:0]  w_addi;
  logic [DW-1:0]  w_load;
  logic [DW-1:0]  w_result;
  logic           w_ovf;
  logic           w_jump;
  logic           w_mem_we;

  logic [DW-1:0]  r_mem [DMEM_DEPTH];
  logic           r_wb_valid;
  logic           r_wb_en;
  logic [RW-1:0]  r_wb_addr;
  logic [DW-1:0]  r_wb_data;
  logic           r_jump;
  logic           r_ovf;

  assign w_opcode = bus.instruction[7:4];
  assign w_fa     = bus.instruction[3:2];
  assign w_fb     = bus.instruction[1:0];

  // Register-address decode; unused read ports drive 0
  always_comb begin
    w_ra0  = '0;
    w_ra1  = '0;
    w_dest = '0;
    w_we   = 1'b0;
    case (w_opcode)
      OP_ADDI: begin
        w_ra0  = w_fa;
        w_dest = w_fa;
        w_we   = 1'b1;
      end
      OP_LW: begin
        w_ra0  = w_fb;
        w_dest = w_fa;
        w_we   = 1'b1;
      end
      OP_SW: begin
        w_ra0 = w_fb;
        w_ra1 = w_fa;
      end
      OP_BEQ, OP_BNE: begin
        w_ra0 = w_fa;
        w_ra1 = w_fb;
      end
      OP_J: begin
      end
      OP_JAL: begin
        w_dest = 2'b11;
        w_we   = 1'b1;
      end
      default: begin
        w_ra0  = w_fa;
        w_ra1  = w_fb;
        w_dest = w_fa;
        w_we   = 1'b1;
      end
    endcase
  end

  assign bus.reg_addr_0 = w_ra0;
  assign bus.reg_addr_1 = w_ra1;

  assign w_add  = bus.op_a + bus.op_b;
  assign w_sub  = bus.op_a - bus.op_b;
  assign w_addi = bus.op_a + DW'(w_fb);
  assign w_load = r_mem[bus.op_a];

  // ALU, overflow, branch resolution and store enable
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    w_jump   = 1'b0;
    w_mem_we = 1'b0;
    case (w_opcode)
      OP_ADD: begin
        w_result = w_add;
        w_ovf    = (bus.op_a[7] == bus.op_b[7]) && (w_add[7] != bus.op_a[7]);
      end
      OP_SUB: begin
        w_result = w_sub;
        w_ovf    = (bus.op_a[7] != bus.op_b[7]) && (w_sub[7] != bus.op_a[7]);
      end
      OP_AND:  w_result = bus.op_a & bus.op_b;
      OP_OR:   w_result = bus.op_a | bus.op_b;
      OP_XOR:  w_result = bus.op_a ^ bus.op_b;
      OP_SLT:  w_result = DW'($signed(bus.op_a) < $signed(bus.op_b));
      OP_SLL:  w_result = bus.op_a << bus.op_b[2:0];
      OP_SRL:  w_result = bus.op_a >> bus.op_b[2:0];
      OP_MOV:  w_result = bus.op_b;
      OP_ADDI: begin
        w_result = w_addi;
        // immediate is non-negative, so only a positive-to-negative wrap overflows
        w_ovf    = !bus.op_a[7] && w_addi[7];
      end
      OP_LW:   w_result = w_load;
      OP_SW:   w_mem_we = bus.instr_valid;
      OP_BEQ:  w_jump = (bus.op_a == bus.op_b);
      OP_BNE:  w_jump = (bus.op_a != bus.op_b);
      OP_J:    w_jump = 1'b1;
      OP_JAL: begin
        w_result = bus.pc + DW'(1);
        w_jump   = 1'b1;
      end
      default: w_result = '0;
    endcase
  end

  // Data memory; the load path reads before this edge's store lands
`ifdef DMEM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DMEM_DEPTH); i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[bus.op_a] <= bus.op_b;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[bus.op_a] <= bus.op_b;
  end
`endif

  // Write-back registers; idle cycles drop strobes and hold payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_jump     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wb_valid <= bus.instr_valid;
      if (bus.instr_valid) begin
        r_wb_en   <= w_we;
        r_wb_addr <= w_dest;
        r_wb_data <= w_result;
        r_jump    <= w_jump;
        r_ovf     <= w_ovf;
      end else begin
        r_wb_en <= 1'b0;
        r_jump  <= 1'b0;
      end
    end
  end

  assign bus.wb_valid = r_wb_valid;
  assign bus.wb_en    = r_wb_en;
  assign bus.wb_addr  = r_wb_addr;
  assign bus.wb_data  = r_wb_data;
  assign bus.jump     = r_jump;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_exec_datapath.sv
// Self-checking bench for exec_datapath: vector table plus scoreboard queue,
// with hand-written idle, reset and memory-persistence sequences.
module tb_exec_datapath;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_datapath_if bus ();

  exec_datapath dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [7:0] instr;
    logic [7:0] pc;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] ra0;
    logic [1:0] ra1;
    logic       en;
    logic [1:0] addr;
    logic [7:0] data;
    logic       jump;
    logic       ov;
    logic       chk;
  } vec_t;

  typedef struct {
    string      name;
    logic       v;
    logic       en;
    logic [1:0] addr;
    logic [7:0] data;
    logic       jump;
    logic       ov;
    logic       chk;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(string n, logic [7:0] ins, logic [7:0] pc, logic [7:0] a, logic [7:0] b,
                              logic [1:0] ra0, logic [1:0] ra1, logic en, logic [1:0] ad,
                              logic [7:0] d, logic j, logic ov, logic chk);
    vec_t t;
    t.name = n; t.instr = ins; t.pc = pc; t.a = a; t.b = b; t.ra0 = ra0; t.ra1 = ra1;
    t.en = en; t.addr = ad; t.data = d; t.jump = j; t.ov = ov; t.chk = chk;
    return t;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [7:0] ins, logic [7:0] pc, logic [7:0] a, logic [7:0] b);
    bus.instr_valid = v;
    bus.instruction = ins;
    bus.pc          = pc;
    bus.op_a        = a;
    bus.op_b        = b;
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    e = sb.pop_front();
    check({e.name, ".wb_valid"}, 8'(bus.wb_valid), 8'(e.v));
    check({e.name, ".wb_en"},    8'(bus.wb_en),    8'(e.en));
    check({e.name, ".jump"},     8'(bus.jump),     8'(e.jump));
    if (e.chk) begin
      check({e.name, ".wb_addr"},  8'(bus.wb_addr),  8'(e.addr));
      check({e.name, ".wb_data"},  bus.wb_data,      e.data);
      check({e.name, ".overflow"}, 8'(bus.overflow), 8'(e.ov));
    end else begin
      check({e.name, ".overflow"}, 8'(bus.overflow), 8'(e.ov));
    end
  endtask

  // One valid instruction: drive on negedge, check decode, score after the edge
  task automatic apply(vec_t t);
    exp_t e;
    @(negedge clk);
    drive(1'b1, t.instr, t.pc, t.a, t.b);
    #1;
    check({t.name, ".reg_addr_0"}, 8'(bus.reg_addr_0), 8'(t.ra0));
    check({t.name, ".reg_addr_1"}, 8'(bus.reg_addr_1), 8'(t.ra1));
    e.name = t.name; e.v = 1'b1; e.en = t.en; e.addr = t.addr; e.data = t.data;
    e.jump = t.jump; e.ov = t.ov; e.chk = t.chk;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_compare();
  endtask

  task automatic check_all_zero(string name);
    check({name, ".wb_valid"}, 8'(bus.wb_valid), 8'h00);
    check({name, ".wb_en"},    8'(bus.wb_en),    8'h00);
    check({name, ".wb_addr"},  8'(bus.wb_addr),  8'h00);
    check({name, ".wb_data"},  bus.wb_data,      8'h00);
    check({name, ".jump"},     8'(bus.jump),     8'h00);
    check({name, ".overflow"}, 8'(bus.overflow), 8'h00);
  endtask

  initial begin
    exp_t e;
    //                name      instr  pc     a      b      ra0 ra1 en addr data  j  ov chk
    vecs.push_back(mk("add_ov",  8'h08, 8'h00, 8'h7F, 8'h01, 2,  0,  1, 2,  8'h80, 0, 1, 1));
    vecs.push_back(mk("sub",     8'h17, 8'h00, 8'h05, 8'h07, 1,  3,  1, 1,  8'hFE, 0, 0, 1));
    vecs.push_back(mk("sub_ov",  8'h1E, 8'h00, 8'h80, 8'h01, 3,  2,  1, 3,  8'h7F, 0, 1, 1));
    vecs.push_back(mk("and",     8'h21, 8'h00, 8'hF0, 8'h3C, 0,  1,  1, 0,  8'h30, 0, 0, 1));
    vecs.push_back(mk("or",      8'h36, 8'h00, 8'hF0, 8'h0F, 1,  2,  1, 1,  8'hFF, 0, 0, 1));
    vecs.push_back(mk("xor",     8'h4B, 8'h00, 8'hFF, 8'h0F, 2,  3,  1, 2,  8'hF0, 0, 0, 1));
    vecs.push_back(mk("slt_t",   8'h59, 8'h00, 8'hFF, 8'h01, 2,  1,  1, 2,  8'h01, 0, 0, 1));
    vecs.push_back(mk("slt_f",   8'h59, 8'h00, 8'h01, 8'hFF, 2,  1,  1, 2,  8'h00, 0, 0, 1));
    vecs.push_back(mk("sll",     8'h6E, 8'h00, 8'h81, 8'h09, 3,  2,  1, 3,  8'h02, 0, 0, 1));
    vecs.push_back(mk("srl",     8'h74, 8'h00, 8'h81, 8'h0B, 1,  0,  1, 1,  8'h10, 0, 0, 1));
    vecs.push_back(mk("mov",     8'h8D, 8'h00, 8'h00, 8'h5A, 3,  1,  1, 3,  8'h5A, 0, 0, 1));
    vecs.push_back(mk("addi_ov", 8'h97, 8'h00, 8'h7E, 8'h00, 1,  0,  1, 1,  8'h81, 0, 1, 1));
    vecs.push_back(mk("addi",    8'h97, 8'h00, 8'h10, 8'h00, 1,  0,  1, 1,  8'h13, 0, 0, 1));
    vecs.push_back(mk("beq_t",   8'hC6, 8'h00, 8'h33, 8'h33, 1,  2,  0, 0,  8'h00, 1, 0, 0));
    vecs.push_back(mk("bne_f",   8'hD6, 8'h00, 8'h33, 8'h33, 1,  2,  0, 0,  8'h00, 0, 0, 0));
    vecs.push_back(mk("bne_t",   8'hD6, 8'h00, 8'h33, 8'h34, 1,  2,  0, 0,  8'h00, 1, 0, 0));
    vecs.push_back(mk("beq_f",   8'hC6, 8'h00, 8'h33, 8'h34, 1,  2,  0, 0,  8'h00, 0, 0, 0));
    vecs.push_back(mk("j",       8'hE5, 8'h40, 8'h12, 8'h34, 0,  0,  0, 0,  8'h00, 1, 0, 0));
    vecs.push_back(mk("jal",     8'hF5, 8'hFF, 8'h12, 8'h34, 0,  0,  1, 3,  8'h00, 1, 0, 1));
    vecs.push_back(mk("sw",      8'hB6, 8'h00, 8'h10, 8'hA5, 2,  1,  0, 0,  8'h00, 0, 0, 0));
    vecs.push_back(mk("lw",      8'hA4, 8'h00, 8'h10, 8'h00, 0,  0,  1, 1,  8'hA5, 0, 0, 1));
    vecs.push_back(mk("add_wrap",8'h00, 8'h00, 8'h80, 8'h80, 0,  0,  1, 0,  8'h00, 0, 1, 1));

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Idle cycle after an overflowing add: strobes drop, payload holds, no store
    apply(mk("pre_idle", 8'h08, 8'h00, 8'h7F, 8'h01, 2, 0, 1, 2, 8'h80, 0, 1, 1));
    @(negedge clk);
    drive(1'b0, 8'hB6, 8'h00, 8'h10, 8'h11);
    e.name = "idle"; e.v = 1'b0; e.en = 1'b0; e.addr = 2'd2; e.data = 8'h80;
    e.jump = 1'b0; e.ov = 1'b1; e.chk = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_compare();
    apply(mk("lw_after_idle", 8'hA4, 8'h00, 8'h10, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 0, 1));

    // Idle after a jump clears jump
    apply(mk("j2", 8'hE0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 1, 0, 0));
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check("idle_after_j.jump", 8'(bus.jump), 8'h00);
    apply(mk("lw_pre_rst", 8'hA4, 8'h00, 8'h10, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 0, 1));

    // Reset mid-instruction: immediate clear, the in-flight add is discarded
    @(negedge clk);
    drive(1'b1, 8'h08, 8'h00, 8'h7F, 8'h01);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    @(posedge clk);
    #1 check_all_zero("rst_hold");
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;

`ifdef DMEM_RESET_CLEAR_EN
    apply(mk("lw_post_rst", 8'hA4, 8'h00, 8'h10, 8'h00, 0, 0, 1, 1, 8'h00, 0, 0, 1));
`else
    apply(mk("lw_post_rst", 8'hA4, 8'h00, 8'h10, 8'h00, 0, 0, 1, 1, 8'hA5, 0, 0, 1));
`endif

    check("sb_drained", 8'(sb.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
